// File: rtl/uart_rx_pkg.sv
// Shared types and width helpers for the UART receive front end.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK,
        LOAD
    } rx_state_t;

    // Clock edges after reset release before s_prev holds a real line sample.
    localparam int SYNC_FILL = 3;

    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit) + 1;
    endfunction

    function automatic int idx_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/uart_rx_core_timer.sv
// Bit-period and bit-index counters that pace mid-bit sampling of a frame.
module rx_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    input  logic half_phase,
    output logic sample_strobe,
    output logic bits_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = idx_width(DATA_BITS);
    localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS);

    logic [CW-1:0] bit_cnt;
    logic [IW-1:0] bit_idx;

    // The start phase starts from 0 so it ends one cycle short of a full half bit,
    // landing the strobe on the edge CLKS_PER_BIT/2 after leaving IDLE.
    assign sample_strobe = enable && (bit_cnt == (half_phase ? HALF_TERM : FULL_TERM));
    assign bits_done     = (bit_idx == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (enable) begin
            if (sample_strobe) begin
                bit_cnt <= CW'(1);
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (sample_strobe && !half_phase && !bits_done) begin
                bit_idx <= bit_idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: line synchronizer, frame FSM, shift register and
// data_ready/data_read handshake with overrun and framing error flags.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    rx_state_t state, next_state;

    logic                 s_meta, s_in, s_prev;
    logic [1:0]           warm;
    logic                 start_seen;
    logic                 sample_strobe, bits_done;
    logic [DATA_BITS-1:0] shift_reg;

    // The synchronizer resets to idle-high, so until it has flushed those values
    // a line held low through reset must not look like a falling edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s_meta <= 1'b1;
            s_in   <= 1'b1;
            s_prev <= 1'b1;
            warm   <= '0;
        end else begin
            s_meta <= serial_in;
            s_in   <= s_meta;
            s_prev <= s_in;
            if (warm != 2'(SYNC_FILL)) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign start_seen = (warm == 2'(SYNC_FILL)) && s_prev && !s_in;

    rx_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (state != IDLE),
        .clear        (state == IDLE),
        .half_phase   (state == START_CHK),
        .sample_strobe(sample_strobe),
        .bits_done    (bits_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_seen) next_state = START_CHK;
            START_CHK: if (sample_strobe) next_state = s_in ? IDLE : RECV;
            RECV:      if (bits_done) next_state = STOP_CHK;
            STOP_CHK:  if (sample_strobe) next_state = s_in ? LOAD : IDLE;
            LOAD:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // A load always wins over a same-cycle read; the read then only cancels the overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg     <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (state == RECV && sample_strobe) begin
                shift_reg <= {s_in, shift_reg[DATA_BITS-1:1]};
            end

            if (state == IDLE && start_seen) begin
                framing_error <= 1'b0;
            end else if (state == STOP_CHK && sample_strobe && !s_in) begin
                framing_error <= 1'b1;
            end

            if (state == LOAD) begin
                rx_data       <= shift_reg;
                data_ready    <= 1'b1;
                overrun_error <= data_read ? 1'b0 : (overrun_error | data_ready);
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized and directed bench for uart_rx_core, checked every cycle against a
// frame-timing model built from line history and sample offsets.
module tb_uart_rx_core;

    localparam int C  = 10;
    localparam int H  = C / 2;
    localparam int DB = 8;

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_read = 1'b0;
    logic [7:0] rx_data;
    logic       data_ready, overrun_error, framing_error;

    int tests = 0;
    int fails = 0;
    bit rand_rd = 1'b0;

    uart_rx_core #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (DB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: hist[n] is the line seen at edge n; the core acts at edge n
    // on hist[n-2], and a start needs a real high at n-3 followed by a low at n-2.
    bit         hist [0:32767];
    int         cyc = 0, first_edge = 0, t0 = 0, off;
    bit         in_rst = 1'b1, busy = 1'b0, ld, s;
    logic [7:0] acc = '0, m_data = '0;
    bit         m_ready = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy = 0; in_rst = 1;
            m_data = '0; m_ready = 0; m_ovr = 0; m_fe = 0;
        end else begin
            if (in_rst) begin
                first_edge = cyc;
                in_rst = 0;
            end
            hist[cyc] = serial_in;
            ld = 0;
            if (busy) begin
                off = cyc - t0;
                s   = hist[cyc-2];
                if (off == H) begin
                    if (s) busy = 0;
                end else if (off > H && off <= H + DB*C && (off - H) % C == 0) begin
                    acc[(off - H) / C - 1] = s;
                end else if (off == H + (DB+1)*C) begin
                    if (!s) begin
                        m_fe = 1;
                        busy = 0;
                    end
                end else if (off == H + (DB+1)*C + 1) begin
                    ld = 1;
                    busy = 0;
                end
            end else if (cyc - 3 >= first_edge && hist[cyc-3] && !hist[cyc-2]) begin
                busy = 1;
                t0   = cyc;
                m_fe = 0;
            end
            if (ld) begin
                m_ovr   = data_read ? 1'b0 : (m_ovr | m_ready);
                m_ready = 1;
                m_data  = acc;
            end else if (data_read) begin
                m_ready = 0;
                m_ovr   = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        check_output("model_rx_data", rx_data, m_data);
        check_output("model_data_ready", {7'd0, data_ready}, {7'd0, m_ready});
        check_output("model_overrun", {7'd0, overrun_error}, {7'd0, m_ovr});
        check_output("model_framing", {7'd0, framing_error}, {7'd0, m_fe});
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rd) data_read = ($urandom_range(0, 15) == 0);
    end

    // Start bit is driven just after edge e0, so the core leaves IDLE at e0+3
    // and the byte lands at e0+99.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_load,
                              input logic chk_t);
        @(posedge clk); #1 serial_in = 1'b0;
        for (int k = 0; k < DB; k++) begin
            repeat (C) @(posedge clk);
            #1 serial_in = b[k];
        end
        repeat (C) @(posedge clk);
        #1 serial_in = stop;
        repeat (7) @(posedge clk);
        #1 check_output("fe_clear_in_frame", {7'd0, framing_error}, 8'd0);
        @(posedge clk); #1;
        if (chk_t) check_output("ready_before_load", {7'd0, data_ready}, 8'd0);
        if (rd_load) data_read = 1'b1;
        @(posedge clk); #1;
        if (rd_load) data_read = 1'b0;
        if (stop) begin
            check_output("frame_data", rx_data, b);
            check_output("frame_ready", {7'd0, data_ready}, 8'd1);
        end else begin
            check_output("frame_fe", {7'd0, framing_error}, 8'd1);
        end
        @(posedge clk); #1 serial_in = 1'b1;
    endtask

    task automatic read_pulse();
        @(posedge clk); #1 data_read = 1'b1;
        @(posedge clk); #1 data_read = 1'b0;
    endtask

    task automatic apply_stimulus();
        int gap, len;
        rand_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                len = $urandom_range(1, 3);
                @(posedge clk); #1 serial_in = 1'b0;
                repeat (len) @(posedge clk);
                #1 serial_in = 1'b1;
                repeat (10) @(posedge clk);
            end
            gap = $urandom_range(0, 10);
            repeat (gap) @(posedge clk);
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 1'b0, 1'b0);
        end
        rand_rd = 1'b0;
        @(posedge clk); #2 data_read = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        check_output("reset_rx_data", rx_data, 8'h00);
        check_output("reset_ready", {7'd0, data_ready}, 8'd0);
        check_output("reset_overrun", {7'd0, overrun_error}, 8'd0);
        check_output("reset_framing", {7'd0, framing_error}, 8'd0);
        repeat (10) @(posedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check_output("a5_overrun", {7'd0, overrun_error}, 8'd0);
        check_output("a5_framing", {7'd0, framing_error}, 8'd0);
        read_pulse();
        check_output("a5_read_clears", {7'd0, data_ready}, 8'd0);

        @(posedge clk); #1 serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1 check_output("glitch_ready", {7'd0, data_ready}, 8'd0);
        check_output("glitch_data", rx_data, 8'hA5);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check_output("fe_ready", {7'd0, data_ready}, 8'd0);
        check_output("fe_data_kept", rx_data, 8'hA5);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check_output("b2b_data", rx_data, 8'h22);
        check_output("b2b_overrun", {7'd0, overrun_error}, 8'd1);
        check_output("b2b_fe_cleared", {7'd0, framing_error}, 8'd0);
        read_pulse();
        check_output("b2b_read_ready", {7'd0, data_ready}, 8'd0);
        check_output("b2b_read_overrun", {7'd0, overrun_error}, 8'd0);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        check_output("loadrd_ready", {7'd0, data_ready}, 8'd1);
        check_output("loadrd_overrun", {7'd0, overrun_error}, 8'd0);

        @(posedge clk); #1 serial_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (C) @(posedge clk);
            #1 serial_in = 1'b1;
        end
        repeat (C + 4) @(posedge clk);
        #1 n_rst = 1'b0;
        serial_in = 1'b0;
        #1 check_output("midrst_data", rx_data, 8'h00);
        check_output("midrst_ready", {7'd0, data_ready}, 8'd0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (150) @(posedge clk);
        #1 check_output("low_after_rst_fe", {7'd0, framing_error}, 8'd0);
        check_output("low_after_rst_ready", {7'd0, data_ready}, 8'd0);
        serial_in = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check_output("post_rst_overrun", {7'd0, overrun_error}, 8'd0);
        check_output("post_rst_framing", {7'd0, framing_error}, 8'd0);

        apply_stimulus();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end for the lab UART datapath. It synchronizes the asynchronous `serial_in` line and detects start bits. It times mid-bit sampling with internal bit-period and bit-index counters, shifts in data LSB first and checks the stop bit. It presents a received byte to the downstream consumer through a `data_ready`/`data_read` handshake, with overrun and framing error reporting.

## Interface
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..1023.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  asynchronous serial line, idle high.
- data_read  in  1  consumer pulse; acknowledges the current `rx_data`.
- rx_data  out  DATA_BITS  last good byte; reset 0.
- data_ready  out  1  `rx_data` holds an unread byte; reset 0.
- overrun_error  out  1  a byte was overwritten while unread; reset 0.
- framing_error  out  1  last frame had stop bit 0; reset 0.

## Operation
- Synchronizer:
  - `serial_in` passes through a 2-flop synchronizer; both flops reset to 1. This output is `s_in`.
  - A third flop holds `s_prev`, reset 1.
- FSM states: IDLE, START_CHK, RECV, STOP_CHK, LOAD. Reset state is IDLE.
- IDLE:
  - Start is detected when `s_prev`=1 and `s_in`=0.
  - On detect, go to START_CHK, clear the bit-period counter and clear `framing_error`.
- START_CHK:
  - Wait CLKS_PER_BIT/2 cycles (integer floor), then sample `s_in`.
  - If `s_in`=1 (glitch), return to IDLE with no output change.
  - If `s_in`=0, go to RECV.
- RECV:
  - Every CLKS_PER_BIT cycles, sample `s_in` into the shift register, LSB first. Shift right and insert at MSB.
  - After DATA_BITS samples, go to STOP_CHK.
- STOP_CHK:
  - Sample `s_in` after a further CLKS_PER_BIT cycles.
  - If the sample is 1, go to LOAD.
  - If the sample is 0, set `framing_error`, leave `rx_data`/`data_ready` unchanged and go to IDLE.
- LOAD, one cycle:
  - `rx_data` <= shift register and `data_ready` <= 1.
  - If `data_ready` was already 1 and `data_read` is not asserted this cycle, also set `overrun_error` <= 1.
  - Go to IDLE.
- `data_read`=1 in any cycle other than LOAD clears `data_ready` and `overrun_error` on the next edge.
- LOAD and `data_read` in the same cycle: the load wins, `data_ready` stays 1 and no overrun is flagged.
- Bit-period counter:
  - Width is $clog2(CLKS_PER_BIT)+1.
  - It wraps to 1 after reaching its terminal value.
  - It holds at 0 in IDLE.
- Bit-index counter:
  - Width is $clog2(DATA_BITS+1).
  - It is cleared on entry to START_CHK.

## Timing
- T0 is the edge on which the FSM leaves IDLE. It occurs 2–3 cycles after the physical falling edge, due to synchronizer latency.
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit k sample: T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT, for k = 0..DATA_BITS-1.
- Stop sample: T0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
- `data_ready` and `rx_data` update one cycle after the stop sample.
- A new start can be detected from the cycle after LOAD or the framing-error return; back-to-back frames are supported.
- `framing_error` persists until the next start detect or reset.
- Reset mid-frame: all state returns to reset values on the asynchronous assert. The partial frame is discarded, and after release a line held low does not trigger a start until it is seen high first.

## Structure
- Package `uart_rx_pkg` holds:
  - `rx_state_t`, the FSM enum.
  - Localparam helpers for the counter widths.
- One natural sub-module: `rx_timer`.
  - Contains the bit-period and bit-index counters, with enable/clear inputs.
  - Outputs a `sample_strobe` pulse and a `bits_done` flag.
- The FSM, synchronizer, shift register and output registers stay in `uart_rx_core`.

## Test plan
All scenarios use CLKS_PER_BIT=10 and DATA_BITS=8.
- Send frame 0xA5 with stop bit 1 -> `rx_data`=0xA5 and `data_ready`=1 at T0+96; `overrun_error`=0 and `framing_error`=0.
- Drive a 3-cycle low glitch on an idle line -> FSM returns to IDLE; `data_ready` stays 0 and `rx_data` is unchanged.
- Send frame 0x3C with stop bit 0 -> `framing_error`=1 at T0+96; `data_ready` stays 0.
- Send 0x11 then 0x22 back-to-back with no `data_read` -> `rx_data`=0x22, `data_ready`=1 and `overrun_error`=1. Then pulse `data_read` -> both clear next cycle.
- Pulse `data_read` exactly in the LOAD cycle of the second byte -> `data_ready`=1 and `overrun_error`=0.
- Assert `n_rst` at bit 4 of frame 0xFF, release, then send 0x81 -> `rx_data`=0x81 with no errors.
